// File: rtl/jogo_pkg.sv
// Shared definitions for the game input datapath: FSM state codes and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jogo_pkg;

    // Button-detector FSM state codes; 6 and 7 are unused and recover to ESPERA.
    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        FILTRA   = 3'd1,
        ACEITA   = 3'd2,
        INVALIDA = 3'd3,
        SEGURA   = 3'd4,
        SOLTA    = 3'd5
    } estado_t;

    // Default number of stable samples needed to accept a press or a release.
    localparam int DEBOUNCE_CYCLES_PADRAO = 3;

    // True when exactly one bit of v is set (buttons are at most 32 wide).
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous inputs; output is the second stage.
// Latency: 2 clock cycles from input to q.
// Backpressure: none, samples every cycle.
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta_q;
    logic [LARGURA-1:0] meta_d;
    logic [LARGURA-1:0] sinc_q;
    logic [LARGURA-1:0] sinc_d;

    // Shift the raw input through two stages.
    always_comb begin
        meta_d = d;
        sinc_d = meta_q;
    end

    // Both stages clear on reset so a held button looks like a fresh press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= meta_d;
            sinc_q <= sinc_d;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces buttons, rejects multi-button presses, emits one-hot jogada + tem_jogada pulse; DB_CONTAGEM_EN adds a press counter.
// Latency: tem_jogada high in the cycle after edge DEBOUNCE_CYCLES+3 (edge 1 = first edge sampling the press).
// Backpressure: none; habilita=0 at acceptance consumes the press silently, release is still required.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                jogada_invalida,
    output logic                pressionado,
    output logic [2:0]          db_estado,
    output logic [7:0]          db_num_jogadas
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0] amostra;

    estado_t             estado_q;
    estado_t             estado_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [N_BOTOES-1:0] cand_q;
    logic [N_BOTOES-1:0] cand_d;
    logic [N_BOTOES-1:0] jogada_q;
    logic [N_BOTOES-1:0] jogada_d;
    // habilita captured on entry to ACEITA so the pulse stays a pure state decode.
    logic                hab_q;
    logic                hab_d;

    sincronizador_2ff #(
        .LARGURA(N_BOTOES)
    ) u_sinc (
        .clock(clock),
        .reset(reset),
        .d    (botoes),
        .q    (amostra)
    );

    // State register and datapath flops; reset has priority over every transition.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= ESPERA;
            cnt_q    <= '0;
            cand_q   <= '0;
            jogada_q <= '0;
            hab_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            jogada_q <= jogada_d;
            hab_q    <= hab_d;
        end
    end

    // Next-state: filter the press, classify it, then wait for a debounced release.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        jogada_d = jogada_q;
        hab_d    = hab_q;
        case (estado_q)
            ESPERA: begin
                if (amostra != '0) begin
                    estado_d = FILTRA;
                    cand_d   = amostra;
                    cnt_d    = '0;
                end
            end
            FILTRA: begin
                // Any change drops back to ESPERA; the new set is reloaded from there.
                if (amostra != cand_q) begin
                    estado_d = ESPERA;
                end else if (cnt_q == CNT_MAX) begin
                    if (eh_one_hot(32'(cand_q))) begin
                        estado_d = ACEITA;
                        hab_d    = habilita;
                        if (habilita) begin
                            jogada_d = cand_q;
                        end
                    end else begin
                        estado_d = INVALIDA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACEITA: begin
                estado_d = SEGURA;
            end
            INVALIDA: begin
                estado_d = SEGURA;
            end
            SEGURA: begin
                if (amostra == '0) begin
                    estado_d = SOLTA;
                    cnt_d    = '0;
                end
            end
            SOLTA: begin
                // A bounce during release returns to SEGURA, so no auto-repeat.
                if (amostra != '0) begin
                    estado_d = SEGURA;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                estado_d = ESPERA;
                hab_d    = 1'b0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        tem_jogada      = (estado_q == ACEITA) && hab_q;
        jogada_invalida = (estado_q == INVALIDA);
        pressionado     = (estado_q == ACEITA) || (estado_q == INVALIDA) ||
                          (estado_q == SEGURA) || (estado_q == SOLTA);
        db_estado       = estado_q;
        jogada          = jogada_q;
    end

`ifdef DB_CONTAGEM_EN
    logic [7:0] num_q;
    logic [7:0] num_d;

    // Count reported presses, wrapping at 256.
    always_comb begin
        num_d = tem_jogada ? (num_q + 8'd1) : num_q;
    end

    // Press counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            num_q <= 8'd0;
        end else begin
            num_q <= num_d;
        end
    end

    assign db_num_jogadas = num_q;
`else
    assign db_num_jogadas = 8'd0;
`endif

endmodule
